// File: rtl/ts_ep_packer_pkg.sv
// Shared constants and state encoding for the TS endpoint packer.
package ts_pkg;

    localparam logic [7:0]  TS_SYNC     = 8'h47;
    localparam logic [12:0] TS_NULL_PID = 13'h1FFF;
    localparam int unsigned TS_PKT_LEN  = 188;

    typedef enum logic [2:0] {
        HUNT,
        FILL,
        SKIP,
        COMMIT,
        WAIT_ACK
    } ts_state_e;

endpackage

// File: rtl/ts_ep_packer_if.sv
// Endpoint IN-buffer write/commit bus between the packer and usb2_top EP3.
interface ts_ep_packer_if #(
    parameter int unsigned ADDR_W = 11
) ();

    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic              buf_wren;
    logic              buf_ready;
    logic              buf_commit;
    logic [ADDR_W-1:0] buf_commit_len;
    logic              buf_commit_ack;

    modport master (
        output buf_addr, buf_data, buf_wren, buf_commit, buf_commit_len,
        input  buf_ready, buf_commit_ack
    );

    modport slave (
        input  buf_addr, buf_data, buf_wren, buf_commit, buf_commit_len,
        output buf_ready, buf_commit_ack
    );

endinterface

// File: rtl/ts_ep_packer_sat_cnt.sv
// 16-bit counter that increments on enable and sticks at all-ones.
module ts_sat_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] cnt
);

    // Count up, holding at the ceiling instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/ts_ep_packer.sv
// Multi-channel TS packer: aligns the selected stream on 0x47 and writes
// whole packets into the EP3 IN buffer, committing when full or idle.
// Optional build macro TS_NULL_FILTER_EN discards null-PID packets.
module ts_ep_packer
    import ts_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CH_W     = 2,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned PKT_LEN  = TS_PKT_LEN,
    parameter int unsigned FLUSH_TO = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CH_W-1:0]     insel,
    input  logic [NUM_CH-1:0]   ts_valid,
    input  logic [NUM_CH-1:0]   ts_start,
    input  logic [8*NUM_CH-1:0] ts_data,
    input  logic [ADDR_W-1:0]   commit_len,
    ts_ep_packer_if.master      bus,
    output logic                almost_full,
    output logic [15:0]         drop_cnt,
    output logic [15:0]         sync_err_cnt
);

    localparam int unsigned IDX_W    = $clog2(PKT_LEN);
    localparam int unsigned AW1      = ADDR_W + 1;
    localparam bit          FLUSH_EN = (FLUSH_TO != 0);
    localparam int unsigned IDLE_W   = (FLUSH_TO > 1) ? $clog2(FLUSH_TO + 1) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PKT_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_EN ? FLUSH_TO - 1 : 0);

    ts_state_e          state;
    logic [CH_W-1:0]    ch;
    logic [IDX_W-1:0]   byte_idx;
    logic [ADDR_W-1:0]  pkt_base;
    logic               await_ack;
    logic [IDLE_W-1:0]  idle_cnt;

    logic [CH_W-1:0]    eff_ch_c;
    logic               sel_valid_c;
    logic               sel_start_c;
    logic [7:0]         sel_data_c;
    logic               arrive_c;
    logic               writable_c;
    logic               take_c;
    logic               drop_inc_c;
    logic               sync_inc_c;
    logic               flush_hit_c;
    logic               keep_c;
    logic               commit_c;
    logic [AW1-1:0]     room_end_c;

    // Channel mux: HUNT follows insel live, other states stay on the latched channel
    always_comb begin
        eff_ch_c    = (state == HUNT) ? insel : ch;
        sel_valid_c = 1'b0;
        sel_start_c = 1'b0;
        sel_data_c  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == eff_ch_c) begin
                sel_valid_c = ts_valid[k];
                sel_start_c = ts_valid[k] & ts_start[k];
                sel_data_c  = ts_data[8*k +: 8];
            end
        end
    end

    // A start outside SKIP is a new packet: accept, drop, or flag bad sync
    assign arrive_c    = sel_start_c && (state != SKIP);
    assign writable_c  = bus.buf_ready && !await_ack && (state != COMMIT) && (state != WAIT_ACK);
    assign take_c      = arrive_c && (sel_data_c == TS_SYNC) && writable_c;
    assign drop_inc_c  = arrive_c && (sel_data_c == TS_SYNC) && !writable_c;
    assign sync_inc_c  = arrive_c && (sel_data_c != TS_SYNC);
    assign flush_hit_c = FLUSH_EN && (state == HUNT) && (pkt_base != '0) &&
                         !sel_start_c && (idle_cnt == IDLE_LAST);
    assign room_end_c  = {1'b0, pkt_base} + AW1'(2 * PKT_LEN);
    assign commit_c    = keep_c && (room_end_c > {1'b0, commit_len});

`ifdef TS_NULL_FILTER_EN
    logic [12:0] pid;

    assign keep_c = (pid != TS_NULL_PID);

    // Capture the PID from header bytes 1-2 of the packet being filled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pid <= '0;
        end else if ((state == FILL) && sel_valid_c && !sel_start_c) begin
            if (byte_idx == IDX_W'(1)) pid[12:8] <= sel_data_c[4:0];
            if (byte_idx == IDX_W'(2)) pid[7:0]  <= sel_data_c;
        end
    end
`else
    assign keep_c = 1'b1;
`endif

    // Packer FSM with registered buffer-bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= HUNT;
            ch                 <= '0;
            byte_idx           <= '0;
            pkt_base           <= '0;
            await_ack          <= 1'b0;
            idle_cnt           <= '0;
            almost_full        <= 1'b0;
            bus.buf_addr       <= '0;
            bus.buf_data       <= '0;
            bus.buf_wren       <= 1'b0;
            bus.buf_commit     <= 1'b0;
            bus.buf_commit_len <= '0;
        end else begin
            bus.buf_wren   <= 1'b0;
            bus.buf_commit <= 1'b0;
            almost_full    <= (state == COMMIT) || await_ack || !bus.buf_ready;

            if (state == HUNT) ch <= insel;

            if (await_ack && bus.buf_commit_ack) begin
                await_ack <= 1'b0;
                pkt_base  <= '0;
            end

            if (!FLUSH_EN || (state != HUNT) || (pkt_base == '0) || sel_start_c || flush_hit_c)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + IDLE_W'(1);

            if (take_c) begin
                bus.buf_wren <= 1'b1;
                bus.buf_addr <= pkt_base;
                bus.buf_data <= sel_data_c;
                byte_idx     <= IDX_W'(1);
                state        <= FILL;
            end else if (drop_inc_c && (state != COMMIT)) begin
                byte_idx <= IDX_W'(1);
                state    <= SKIP;
            end else begin
                case (state)
                    HUNT: begin
                        if (flush_hit_c) state <= COMMIT;
                    end
                    FILL: begin
                        if (sync_inc_c) begin
                            byte_idx <= '0;
                            state    <= HUNT;
                        end else if (sel_valid_c) begin
                            bus.buf_wren <= 1'b1;
                            bus.buf_addr <= pkt_base + ADDR_W'(byte_idx);
                            bus.buf_data <= sel_data_c;
                            if (byte_idx == LAST_IDX) begin
                                byte_idx <= '0;
                                if (keep_c) pkt_base <= pkt_base + ADDR_W'(PKT_LEN);
                                state <= commit_c ? COMMIT : HUNT;
                            end else begin
                                byte_idx <= byte_idx + IDX_W'(1);
                            end
                        end
                    end
                    SKIP: begin
                        if (sel_valid_c) begin
                            if (byte_idx == LAST_IDX) begin
                                byte_idx <= '0;
                                state    <= (await_ack && !bus.buf_commit_ack) ? WAIT_ACK : HUNT;
                            end else begin
                                byte_idx <= byte_idx + IDX_W'(1);
                            end
                        end
                    end
                    COMMIT: begin
                        bus.buf_commit     <= 1'b1;
                        bus.buf_commit_len <= pkt_base;
                        await_ack          <= 1'b1;
                        state              <= WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        if (bus.buf_commit_ack) state <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    ts_sat_cnt u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_inc_c),
        .cnt   (drop_cnt)
    );

    ts_sat_cnt u_sync_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (sync_inc_c),
        .cnt   (sync_err_cnt)
    );

endmodule

// File: tb/tb_ts_ep_packer.sv
// Directed bench for ts_ep_packer; the null-PID case runs under TS_NULL_FILTER_EN.
module tb_ts_ep_packer;
    import ts_pkg::*;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned CH_W     = 2;
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned FLUSH_TO = 300;

    logic                clk = 1'b0;
    logic                reset;
    logic [CH_W-1:0]     insel;
    logic [NUM_CH-1:0]   ts_valid;
    logic [NUM_CH-1:0]   ts_start;
    logic [8*NUM_CH-1:0] ts_data;
    logic [ADDR_W-1:0]   commit_len;
    logic                almost_full;
    logic [15:0]         drop_cnt;
    logic [15:0]         sync_err_cnt;

    ts_ep_packer_if #(.ADDR_W(ADDR_W)) bus ();

    ts_ep_packer #(
        .NUM_CH   (NUM_CH),
        .CH_W     (CH_W),
        .ADDR_W   (ADDR_W),
        .PKT_LEN  (188),
        .FLUSH_TO (FLUSH_TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .insel        (insel),
        .ts_valid     (ts_valid),
        .ts_start     (ts_start),
        .ts_data      (ts_data),
        .commit_len   (commit_len),
        .bus          (bus),
        .almost_full  (almost_full),
        .drop_cnt     (drop_cnt),
        .sync_err_cnt (sync_err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wr_q[$];
    int cm_q[$];
    int exp_q[$];
    bit win = 1'b0;
    int win_af_low;
    int win_wr;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Record every buffer write and commit as seen by the endpoint
    always @(negedge clk) begin
        if (reset) begin
            wr_q.delete();
            cm_q.delete();
            win_af_low <= 0;
            win_wr     <= 0;
        end else begin
            if (bus.buf_wren) wr_q.push_back(int'(bus.buf_addr) * 256 + int'(bus.buf_data));
            if (bus.buf_commit) cm_q.push_back(int'(bus.buf_commit_len));
            if (win) begin
                if (!almost_full) win_af_low <= win_af_low + 1;
                if (bus.buf_wren) win_wr <= win_wr + 1;
            end
        end
    end

    function automatic logic [7:0] pbyte(input logic [7:0] sync, input logic [12:0] pid,
                                         input int seed, input int i);
        if (i == 0) return sync;
        if (i == 1) return {3'b000, pid[12:8]};
        if (i == 2) return pid[7:0];
        return 8'((seed + 3 * i) & 255);
    endfunction

    function automatic int cm_at(input int i);
        return (i < cm_q.size()) ? cm_q[i] : -1;
    endfunction

    task automatic send_pkt(input int ch, input logic [7:0] sync, input logic [12:0] pid,
                            input int seed, input int len, input int sw_at, input int noise_ch);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            ts_valid = '0;
            ts_start = '0;
            ts_data  = '0;
            ts_valid[ch] = 1'b1;
            ts_start[ch] = (i == 0);
            ts_data[8*ch +: 8] = pbyte(sync, pid, seed, i);
            if (noise_ch >= 0) begin
                ts_valid[noise_ch] = 1'b1;
                ts_start[noise_ch] = 1'b1;
                ts_data[8*noise_ch +: 8] = 8'h48;
            end
            if (i == sw_at) insel = CH_W'(1);
        end
    endtask

    task automatic push_exp(input int base, input logic [7:0] sync, input logic [12:0] pid,
                            input int seed, input int len);
        for (int i = 0; i < len; i++)
            exp_q.push_back((base + i) * 256 + int'(pbyte(sync, pid, seed, i)));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ts_valid = '0;
            ts_start = '0;
        end
    endtask

    task automatic wait_commits(input int n, input int budget);
        for (int c = 0; c < budget && cm_q.size() < n; c++) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        bus.buf_commit_ack = 1'b1;
        @(negedge clk);
        bus.buf_commit_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        insel              = '0;
        ts_valid           = '0;
        ts_start           = '0;
        ts_data            = '0;
        commit_len         = ADDR_W'(1020);
        bus.buf_ready      = 1'b1;
        bus.buf_commit_ack = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= wr_q.size() || wr_q[i] != exp_q[i]) bad++;
        chk({tag, "_wrdata"}, bad, 0);
    endtask

    initial begin
        reset = 1'b1;

        // Reset values
        do_reset();
        chk("rst_wren",   int'(bus.buf_wren), 0);
        chk("rst_commit", int'(bus.buf_commit), 0);
        chk("rst_addr",   int'(bus.buf_addr), 0);
        chk("rst_af",     int'(almost_full), 0);
        chk("rst_drop",   int'(drop_cnt), 0);
        chk("rst_sync",   int'(sync_err_cnt), 0);

        // Channel 2: five packets fill 940 bytes, sixth goes out on flush
        do_reset();
        insel = CH_W'(2);
        for (int p = 0; p < 5; p++) begin
            push_exp(188 * p, TS_SYNC, 13'h0100 + 13'(p), 17 * p, 188);
            send_pkt(2, TS_SYNC, 13'h0100 + 13'(p), 17 * p, 188, -1, -1);
        end
        idle(1);
        wait_commits(1, 50);
        chk("t1_commit0", cm_at(0), 940);
        idle(10);
        pulse_ack();
        push_exp(0, TS_SYNC, 13'h0105, 85, 188);
        send_pkt(2, TS_SYNC, 13'h0105, 85, 188, -1, -1);
        idle(1);
        wait_commits(2, FLUSH_TO + 100);
        chk("t1_ncommit", cm_q.size(), 2);
        chk("t1_commit1", cm_at(1), 188);
        pulse_ack();
        check_writes("t1");
        chk("t1_drop", int'(drop_cnt), 0);

        // Bad sync byte, then a good packet lands at address 0
        do_reset();
        send_pkt(0, 8'h48, 13'h0020, 5, 188, -1, -1);
        idle(2);
        chk("t2_sync", int'(sync_err_cnt), 1);
        chk("t2_nowr", wr_q.size(), 0);
        push_exp(0, TS_SYNC, 13'h0021, 9, 188);
        send_pkt(0, TS_SYNC, 13'h0021, 9, 188, -1, -1);
        idle(1);
        wait_commits(1, FLUSH_TO + 100);
        chk("t2_commit", cm_at(0), 188);
        pulse_ack();
        check_writes("t2");

        // commit_len below one packet; ack withheld while two packets arrive
        do_reset();
        commit_len = ADDR_W'(100);
        push_exp(0, TS_SYNC, 13'h0030, 3, 188);
        send_pkt(0, TS_SYNC, 13'h0030, 3, 188, -1, -1);
        idle(1);
        wait_commits(1, 20);
        chk("t3_commit", cm_at(0), 188);
        win = 1'b1;
        send_pkt(0, TS_SYNC, 13'h0031, 4, 188, -1, -1);
        send_pkt(0, TS_SYNC, 13'h0032, 6, 188, -1, -1);
        idle(120);
        win = 1'b0;
        @(negedge clk);
        chk("t3_drop",   int'(drop_cnt), 2);
        chk("t3_af_low", win_af_low, 0);
        chk("t3_wr",     win_wr, 0);
        chk("t3_ncommit", cm_q.size(), 1);
        pulse_ack();
        idle(3);
        chk("t3_af_rel", int'(almost_full), 0);
        check_writes("t3");

        // Start reasserted at byte 100 rewinds to the packet base
        do_reset();
        push_exp(0, TS_SYNC, 13'h0040, 11, 100);
        send_pkt(0, TS_SYNC, 13'h0040, 11, 100, -1, -1);
        push_exp(0, TS_SYNC, 13'h0041, 12, 188);
        send_pkt(0, TS_SYNC, 13'h0041, 12, 188, -1, -1);
        push_exp(188, TS_SYNC, 13'h0042, 13, 188);
        send_pkt(0, TS_SYNC, 13'h0042, 13, 188, -1, -1);
        idle(1);
        wait_commits(1, FLUSH_TO + 100);
        chk("t4_commit", cm_at(0), 376);
        pulse_ack();
        check_writes("t4");
        chk("t4_drop", int'(drop_cnt), 0);
        chk("t4_sync", int'(sync_err_cnt), 0);

        // insel 0->1 mid-packet with noise starts on channel 1
        do_reset();
        push_exp(0, TS_SYNC, 13'h0050, 21, 188);
        send_pkt(0, TS_SYNC, 13'h0050, 21, 188, 50, 1);
        push_exp(188, TS_SYNC, 13'h0051, 22, 188);
        send_pkt(1, TS_SYNC, 13'h0051, 22, 188, -1, -1);
        idle(1);
        wait_commits(1, FLUSH_TO + 100);
        chk("t5_commit", cm_at(0), 376);
        pulse_ack();
        check_writes("t5");
        chk("t5_sync", int'(sync_err_cnt), 0);

        // Endpoint not ready: packet is dropped without writes
        do_reset();
        bus.buf_ready = 1'b0;
        send_pkt(0, TS_SYNC, 13'h0060, 31, 188, -1, -1);
        idle(2);
        chk("t6_drop", int'(drop_cnt), 1);
        chk("t6_af",   int'(almost_full), 1);
        chk("t6_nowr", wr_q.size(), 0);
        bus.buf_ready = 1'b1;

`ifdef TS_NULL_FILTER_EN
        // Null-PID packet is written then overwritten by the next packet
        do_reset();
        push_exp(0, TS_SYNC, 13'h0070, 41, 188);
        send_pkt(0, TS_SYNC, 13'h0070, 41, 188, -1, -1);
        push_exp(188, TS_SYNC, TS_NULL_PID, 42, 188);
        send_pkt(0, TS_SYNC, TS_NULL_PID, 42, 188, -1, -1);
        push_exp(188, TS_SYNC, 13'h0071, 43, 188);
        send_pkt(0, TS_SYNC, 13'h0071, 43, 188, -1, -1);
        idle(1);
        wait_commits(1, FLUSH_TO + 100);
        chk("t7_commit", cm_at(0), 376);
        pulse_ack();
        check_writes("t7");
        chk("t7_drop", int'(drop_cnt), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ts_ep_packer.md
Name: ts_ep_packer

Overview:
- Parametrised successor to the single-source TS proxy.
- Takes N byte-wide, clk-synchronous TS streams, selects one per `insel`, aligns on 0x47, and writes whole 188-byte packets into the EP3 USB IN buffer.
- Commits a buffer when no further whole packet fits, or when a flush timeout expires.
- Drops whole packets while the endpoint is busy, and counts drops and sync errors.
- Sits between the TS input mux/deserialisers and `usb2_top` EP3 `buf_in_*`.

Parameters:
- NUM_CH, 4, number of TS input channels (1..8).
- CH_W, 2, width of `insel` (`$clog2(NUM_CH)`, min 1).
- ADDR_W, 11, endpoint buffer address width.
- PKT_LEN, 188, TS packet length in bytes.
- FLUSH_TO, 65535, idle cycles before a partial buffer is committed; 0 disables flush.

Ports:
- clk  in  1  single system clock (ULPI 60 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- insel  in  CH_W  channel select; sampled only at packet boundaries.
- ts_valid  in  NUM_CH  per-channel byte valid.
- ts_start  in  NUM_CH  per-channel first-byte-of-packet flag (qualified by valid).
- ts_data  in  8*NUM_CH  per-channel byte; channel k at [8k+7:8k].
- commit_len  in  ADDR_W  maximum bytes per commit, e.g. 1020.
- buf_addr  out  ADDR_W  endpoint write address.
- buf_data  out  8  endpoint write data.
- buf_wren  out  1  endpoint write strobe.
- buf_ready  in  1  endpoint buffer free for writing.
- buf_commit  out  1  one-cycle commit pulse.
- buf_commit_len  out  ADDR_W  bytes in committed buffer.
- buf_commit_ack  in  1  endpoint accepted the commit.
- almost_full  out  1  buffer full or awaiting ack.
- drop_cnt  out  16  saturating count of dropped packets.
- sync_err_cnt  out  16  saturating count of bad sync bytes.

Behaviour:
- Reset values: all outputs 0; state HUNT; internal fill and packet pointers 0; active channel = 0.
- Latency: an accepted byte appears on buf_addr/buf_data/buf_wren one clk later (all registered).
- States:
  - HUNT: latch `insel` as the active channel. On active start&valid:
    - data==0x47 and buf_ready and not WAIT_ACK → write at fill, go FILL.
    - data≠0x47 → sync_err_cnt++, stay in HUNT.
    - data==0x47 but buffer not writable → drop_cnt++, go SKIP.
  - FILL: each valid byte is written at pkt_base+byte_idx.
    - At byte_idx==PKT_LEN-1, commit the packet (pkt_base += PKT_LEN).
    - If pkt_base+2*PKT_LEN > commit_len, go COMMIT; otherwise go HUNT.
    - A start arriving mid-packet aborts it: rewind to pkt_base, no count change, re-enter HUNT handling for that byte in the same cycle.
  - SKIP: consume the active channel until byte_idx==PKT_LEN-1, then go HUNT. No writes.
  - COMMIT: assert buf_commit for one cycle with buf_commit_len=pkt_base, then go WAIT_ACK.
  - WAIT_ACK: on buf_commit_ack, reset pkt_base to 0 and go HUNT.
    - Packets starting in WAIT_ACK go to SKIP with drop_cnt++.
    - Writing resumes only when buf_ready is also high.
- Flush: in HUNT with pkt_base≠0 and no active start for FLUSH_TO cycles → COMMIT (partial buffer). The idle counter clears on every active start.
- almost_full = (state==WAIT_ACK) | (state==COMMIT) | !buf_ready.
- Counters saturate at 16'hFFFF and do not wrap.
- commit_len < PKT_LEN: commit each single packet (minimum one packet per commit).
- Simultaneous start on the active and inactive channels: only the active channel matters.
- An `insel` change mid-packet is ignored until the next HUNT.

Optional Feature:
- Macro: TS_NULL_FILTER_EN.
  - Defined: packets with PID==13'h1FFF (bytes 1–2) are written, then discarded at packet end by not advancing pkt_base. Not counted as drops.
  - Undefined: all packets pass.

Decomposition:
- Package ts_pkg holds:
  - TS_SYNC=8'h47, TS_NULL_PID=13'h1FFF, TS_PKT_LEN=188.
  - State enum {HUNT, FILL, SKIP, COMMIT, WAIT_ACK}.
- One sub-module, ts_sat_cnt (16-bit saturating counter with increment enable), instantiated twice.

Test Plan:
- Ch2 selected, 6 contiguous packets, commit_len=1020, buf_ready=1, ack after 10 cycles → commits of 940 and then, after flush, 188; addresses 0..939 then 0..187.
- Start byte 0x48 on active channel → sync_err_cnt=1, no write, next 0x47 packet written at addr 0.
- ack withheld 500 cycles while 2 packets arrive → drop_cnt=2, almost_full=1 throughout, no wren.
- Start reasserted at byte 100 of a packet → rewind, new packet written at the same pkt_base, final commit_len is a multiple of 188.
- insel switched 0→1 mid-packet → the current channel-0 packet completes, the next packet is taken from channel 1.
- With TS_NULL_FILTER_EN: null PID packet between two valid packets → commit_len=376 after flush.
